// File: rtl/line_buffer_3row.sv
// Three-row raster line buffer: each accepted pixel yields one column (rows r+1, r, r-1),
// and a self-timed flush drains the last row so a frame produces ROWS*COLS columns.
module line_buffer_3row #(
  parameter int unsigned COLS = 400,
  parameter int unsigned ROWS = 400,
  parameter int unsigned DW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] d_i,
  input  logic          valid_i,
  output logic [DW-1:0] d0_o,
  output logic [DW-1:0] d1_o,
  output logic [DW-1:0] d2_o,
  output logic          done_o,
  output logic          frame_done_o,
  output logic          busy_o
);

  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {PRIME, STREAM, FLUSH, FRAME_END} state_t;

  state_t        state, state_next;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [DW-1:0] lb1 [COLS];
  logic [DW-1:0] lb2 [COLS];
  logic [DW-1:0] lb1_rd, lb2_rd;

  logic          last_col, last_row;
  logic          accept, advance, lb1_we, lb2_we, col_out;
  logic [DW-1:0] d0_next, d2_next;

  // Read-before-write: both memories are read at the current column every cycle
  assign lb1_rd   = lb1[col];
  assign lb2_rd   = lb2[col];
  assign last_col = (col == CW'(COLS - 1));
  assign last_row = (row == RW'(ROWS - 1));

  // Next-state, memory write enables and output data selection
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    lb1_we     = 1'b0;
    lb2_we     = 1'b0;
    col_out    = 1'b0;
    d0_next    = d_i;
    d2_next    = lb2_rd;
    case (state)
      PRIME: begin
        accept  = valid_i;
        advance = valid_i;
        lb1_we  = valid_i;
        if (valid_i && last_col) state_next = STREAM;
      end
      STREAM: begin
        accept  = valid_i;
        advance = valid_i;
        lb1_we  = valid_i;
        lb2_we  = valid_i;
        col_out = valid_i;
        // lb2 still holds a previous frame during the first streamed row
        if (row == RW'(1)) d2_next = '0;
        if (valid_i && last_col && last_row) state_next = FLUSH;
      end
      FLUSH: begin
        advance = 1'b1;
        col_out = 1'b1;
        d0_next = '0;
        if (last_col) state_next = FRAME_END;
      end
      FRAME_END: state_next = PRIME;
      default:   state_next = PRIME;
    endcase
  end

  // State and raster position; row only counts accepted pixels so flush leaves it at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PRIME;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_next;
      if (advance) begin
        col <= last_col ? '0 : col + CW'(1);
        if (accept && last_col) row <= last_row ? '0 : row + RW'(1);
      end
    end
  end

  // Line memories carry no reset; stale data is masked by d2_next above
  always_ff @(posedge clk) begin
    if (lb1_we) lb1[col] <= d_i;
    if (lb2_we) lb2[col] <= lb1_rd;
  end

  // busy also covers FRAME_END so every cycle that drops pixels is flagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0_o         <= '0;
      d1_o         <= '0;
      d2_o         <= '0;
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      done_o       <= col_out;
      frame_done_o <= (state == FRAME_END);
      busy_o       <= (state_next == FLUSH) || (state_next == FRAME_END);
      if (col_out) begin
        d0_o <= d0_next;
        d1_o <= lb1_rd;
        d2_o <= d2_next;
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Bench for line_buffer_3row: a ROWS=3 and a ROWS=2 instance share one input stream and
// are compared every cycle against a frame-image model, plus literal column tables.
module tb_line_buffer_3row;

  localparam int unsigned COLS = 4;

  logic       clk, rst, valid_i;
  logic [7:0] d_i;
  logic [7:0] d0_3, d1_3, d2_3, d0_2, d1_2, d2_2;
  logic       done_3, fd_3, busy_3, done_2, fd_2, busy_2;
  logic [31:0] out3, out2;

  line_buffer_3row #(.COLS(COLS), .ROWS(3), .DW(8)) u_dut3 (
    .clk(clk), .rst(rst), .d_i(d_i), .valid_i(valid_i),
    .d0_o(d0_3), .d1_o(d1_3), .d2_o(d2_3),
    .done_o(done_3), .frame_done_o(fd_3), .busy_o(busy_3)
  );

  line_buffer_3row #(.COLS(COLS), .ROWS(2), .DW(8)) u_dut2 (
    .clk(clk), .rst(rst), .d_i(d_i), .valid_i(valid_i),
    .d0_o(d0_2), .d1_o(d1_2), .d2_o(d2_2),
    .done_o(done_2), .frame_done_o(fd_2), .busy_o(busy_2)
  );

  assign out3 = {5'd0, done_3, fd_3, busy_3, d0_3, d1_3, d2_3};
  assign out2 = {5'd0, done_2, fd_2, busy_2, d0_2, d1_2, d2_2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state per instance (0: ROWS=3, 1: ROWS=2)
  int         ph [2];
  int         k  [2];
  int         fc [2];
  logic [7:0] img [2][3][COLS];
  logic [7:0] e_d0 [2];
  logic [7:0] e_d1 [2];
  logic [7:0] e_d2 [2];
  logic       e_done [2];
  logic       e_fd [2];
  logic       e_busy [2];

  logic [23:0] cap3[$];
  logic [23:0] cap2[$];
  int          fd_cnt3, fd_cnt2;

  // Hand-derived column tables for the 1..12 ramp (ROWS=3) and the 1..8 frame (ROWS=2)
  int t3_d0 [12] = '{5, 6, 7, 8, 9, 10, 11, 12, 0, 0, 0, 0};
  int t3_d1 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
  int t3_d2 [12] = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6, 7, 8};
  int t2_d0 [8]  = '{5, 6, 7, 8, 0, 0, 0, 0};
  int t2_d1 [8]  = '{1, 2, 3, 4, 5, 6, 7, 8};
  int t2_d2 [8]  = '{0, 0, 0, 0, 1, 2, 3, 4};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of the model: pixels fill a frame image; columns are read straight from it
  task automatic model_step();
    int rows, r, c;
    for (int m = 0; m < 2; m++) begin
      rows = (m == 0) ? 3 : 2;
      if (rst) begin
        ph[m] = 0; k[m] = 0; fc[m] = 0;
        e_d0[m] = 8'd0; e_d1[m] = 8'd0; e_d2[m] = 8'd0;
        e_done[m] = 1'b0; e_fd[m] = 1'b0; e_busy[m] = 1'b0;
      end else begin
        e_done[m] = 1'b0;
        e_fd[m]   = 1'b0;
        if (ph[m] == 0) begin
          if (valid_i) begin
            r = k[m] / COLS;
            c = k[m] % COLS;
            img[m][r][c] = d_i;
            if (r >= 1) begin
              e_d0[m]   = d_i;
              e_d1[m]   = img[m][r-1][c];
              e_d2[m]   = (r >= 2) ? img[m][r-2][c] : 8'd0;
              e_done[m] = 1'b1;
            end
            k[m]++;
            if (k[m] == rows * COLS) begin
              ph[m] = 1;
              fc[m] = 0;
            end
          end
        end else if (ph[m] == 1) begin
          e_d0[m]   = 8'd0;
          e_d1[m]   = img[m][rows-1][fc[m]];
          e_d2[m]   = img[m][rows-2][fc[m]];
          e_done[m] = 1'b1;
          fc[m]++;
          if (fc[m] == COLS) ph[m] = 2;
        end else begin
          e_fd[m] = 1'b1;
          ph[m]   = 0;
          k[m]    = 0;
        end
        e_busy[m] = (ph[m] != 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("cycle rows3", out3, {5'd0, e_done[0], e_fd[0], e_busy[0], e_d0[0], e_d1[0], e_d2[0]});
    chk("cycle rows2", out2, {5'd0, e_done[1], e_fd[1], e_busy[1], e_d0[1], e_d1[1], e_d2[1]});
    if (done_3) cap3.push_back({d0_3, d1_3, d2_3});
    if (done_2) cap2.push_back({d0_2, d1_2, d2_2});
    if (fd_3) fd_cnt3++;
    if (fd_2) fd_cnt2++;
  endtask

  task automatic drive(input logic vl, input int v);
    valid_i = vl;
    d_i     = 8'(v);
    tick();
  endtask

  task automatic clear_caps();
    cap3.delete();
    cap2.delete();
    fd_cnt3 = 0;
    fd_cnt2 = 0;
  endtask

  task automatic send_frame(input int base);
    for (int i = 1; i <= 12; i++) drive(1'b1, base + i);
  endtask

  task automatic check_ramp(input string tag, input int off);
    logic [7:0] a, b, c;
    chk({tag, " strobes"}, 32'(cap3.size()), 32'd12);
    chk({tag, " frame_done"}, 32'(fd_cnt3), 32'd1);
    for (int i = 0; i < 12; i++) begin
      a = 8'((t3_d0[i] == 0) ? 0 : t3_d0[i] + off);
      b = 8'(t3_d1[i] + off);
      c = 8'((t3_d2[i] == 0) ? 0 : t3_d2[i] + off);
      if (i < cap3.size()) chk($sformatf("%s col %0d", tag, i), 32'(cap3[i]), 32'({a, b, c}));
    end
  endtask

  task automatic check_rows2(input string tag);
    chk({tag, " rows2 strobes"}, 32'(cap2.size()), 32'd8);
    chk({tag, " rows2 frame_done"}, 32'(fd_cnt2), 32'd1);
    for (int i = 0; i < 8; i++)
      if (i < cap2.size())
        chk($sformatf("%s rows2 col %0d", tag, i), 32'(cap2[i]),
            32'({8'(t2_d0[i]), 8'(t2_d1[i]), 8'(t2_d2[i])}));
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; d_i = 8'd0;
    clear_caps();
    repeat (3) tick();
    chk("reset rows3", out3, 32'd0);
    chk("reset rows2", out2, 32'd0);
    rst = 1'b0;

    // Continuous ramp; the ROWS=2 instance sees 1..8 as a frame and drops 9..12 in flush
    clear_caps();
    send_frame(0);
    repeat (6) drive(1'b0, 0);
    check_ramp("ramp", 0);
    check_rows2("ramp");

    // Gaps while priming row 0
    clear_caps();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 0);
      drive(1'b1, i);
    end
    for (int i = 5; i <= 12; i++) drive(1'b1, i);
    repeat (6) drive(1'b0, 0);
    check_ramp("gaps", 0);
    check_rows2("gaps");

    // Pixels offered during flush and frame end must be dropped
    clear_caps();
    send_frame(0);
    repeat (5) drive(1'b1, 99);
    repeat (2) drive(1'b0, 0);
    check_ramp("drop99", 0);

    // Back-to-back frame: first streamed row must not see the previous frame
    clear_caps();
    send_frame(100);
    repeat (6) drive(1'b0, 0);
    check_ramp("second", 100);

    // Abort mid-stream after pixel 7
    for (int i = 1; i <= 7; i++) drive(1'b1, i);
    rst = 1'b1;
    #1;
    chk("abort rows3", out3, 32'd0);
    chk("abort rows2", out2, 32'd0);
    drive(1'b0, 0);
    rst = 1'b0;
    clear_caps();
    send_frame(0);
    repeat (6) drive(1'b0, 0);
    check_ramp("after_rst", 0);
    check_rows2("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
